// File: rtl/prep_ok_quorum_ctrl.sv
// Primary-side PrepareOK quorum collector: tracks per-replica acks and emits commits in order.
// Define PREPOK_STATS_EN to add saturating drop/commit statistics outputs.
module prep_ok_quorum_ctrl #(
  parameter int NUM_REPLICAS = 3,
  parameter int OP_W         = 64,
  parameter int VIEW_W       = 64,
  parameter int WINDOW_LOG2  = 4,
  parameter int IDX_W        = $clog2(NUM_REPLICAS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VIEW_W-1:0] cur_view,
  input  logic [IDX_W-1:0]  my_replica_idx,
  input  logic              issue_val,
  output logic              issue_rdy,
  input  logic              manage_prepok_msg_val,
  output logic              prepok_manage_msg_rdy,
  input  logic [VIEW_W-1:0] msg_view,
  input  logic [OP_W-1:0]   msg_op_num,
  input  logic [IDX_W-1:0]  msg_replica_idx,
  input  logic              view_change_val,
  input  logic [OP_W-1:0]   view_change_op_num,
  output logic              commit_val,
  output logic [OP_W-1:0]   commit_op_num,
  input  logic              commit_rdy,
  output logic [OP_W-1:0]   commit_num,
  output logic [OP_W-1:0]   issue_num,
  output logic              window_full
`ifdef PREPOK_STATS_EN
  ,
  output logic [31:0]       stat_drop_cnt,
  output logic [31:0]       stat_commit_cnt
`endif
);

  // state | meaning
  // IDLE  | accept new issues and PrepareOK messages
  // CHECK | count effective acks >= commit_num+1 against the quorum
  // EMIT  | present commit_num+1 downstream until accepted

  localparam int QUORUM = NUM_REPLICAS / 2 + 1;
  localparam int CNT_W  = $clog2(NUM_REPLICAS + 1);
  localparam logic [OP_W-1:0] WINDOW_SIZE = OP_W'(1) << WINDOW_LOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [OP_W-1:0]  max_ack [NUM_REPLICAS];
  logic [OP_W-1:0]  next_op;
  logic [OP_W-1:0]  sel_ack;
  logic [OP_W-1:0]  eff_ack;
  logic             idx_hit;
  logic             msg_drop;
  logic [CNT_W-1:0] ack_cnt;
  logic             quorum_met;
  logic             msg_fire;
  logic             issue_fire;
  logic             commit_fire;

  assign next_op     = commit_num + OP_W'(1);
  assign window_full = ((issue_num - commit_num) == WINDOW_SIZE);
  assign msg_fire    = manage_prepok_msg_val && prepok_manage_msg_rdy;
  assign issue_fire  = issue_val && issue_rdy;
  assign commit_fire = commit_val && commit_rdy;

  // Out-of-range sender indices simply never match, which makes them drops.
  always_comb begin
    idx_hit = 1'b0;
    sel_ack = '0;
    for (int i = 0; i < NUM_REPLICAS; i++) begin
      if (msg_replica_idx == IDX_W'(i)) begin
        idx_hit = 1'b1;
        sel_ack = max_ack[i];
      end
    end
  end

  assign msg_drop = (msg_view != cur_view) || !idx_hit ||
                    (msg_replica_idx == my_replica_idx) ||
                    (msg_op_num > issue_num) || (msg_op_num <= sel_ack);

  // The primary has logged everything it issued, so its own ack is issue_num.
  always_comb begin
    ack_cnt = '0;
    eff_ack = '0;
    for (int i = 0; i < NUM_REPLICAS; i++) begin
      eff_ack = (IDX_W'(i) == my_replica_idx) ? issue_num : max_ack[i];
      if (eff_ack >= next_op) ack_cnt = ack_cnt + CNT_W'(1);
    end
  end

  assign quorum_met = (ack_cnt >= CNT_W'(QUORUM));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (view_change_val) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (msg_fire && !msg_drop) state_nxt = S_CHECK;
        S_CHECK: state_nxt = ((commit_num < issue_num) && quorum_met) ? S_EMIT : S_IDLE;
        S_EMIT:  if (commit_rdy) state_nxt = S_CHECK;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    issue_rdy             = 1'b0;
    prepok_manage_msg_rdy = 1'b0;
    commit_val            = 1'b0;
    commit_op_num         = next_op;
    case (state)
      S_IDLE: begin
        prepok_manage_msg_rdy = !view_change_val;
        issue_rdy             = !view_change_val && !window_full;
      end
      S_EMIT:  commit_val = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_num <= '0;
      issue_num  <= '0;
      for (int i = 0; i < NUM_REPLICAS; i++) max_ack[i] <= '0;
    end else if (view_change_val) begin
      commit_num <= view_change_op_num;
      issue_num  <= view_change_op_num;
      for (int i = 0; i < NUM_REPLICAS; i++) max_ack[i] <= view_change_op_num;
    end else begin
      if (issue_fire)  issue_num  <= issue_num + OP_W'(1);
      if (commit_fire) commit_num <= commit_num + OP_W'(1);
      if (msg_fire && !msg_drop) begin
        for (int i = 0; i < NUM_REPLICAS; i++) begin
          if (msg_replica_idx == IDX_W'(i)) max_ack[i] <= msg_op_num;
        end
      end
    end
  end

`ifdef PREPOK_STATS_EN
  // Statistics survive view changes; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_drop_cnt   <= '0;
      stat_commit_cnt <= '0;
    end else begin
      if (msg_fire && msg_drop && (stat_drop_cnt != '1))
        stat_drop_cnt <= stat_drop_cnt + 32'd1;
      if (commit_fire && (stat_commit_cnt != '1))
        stat_commit_cnt <= stat_commit_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/prep_ok_quorum_ctrl.md
# prep_ok_quorum_ctrl

Primary-side collector for VR PrepareOK messages. Each PrepareOK is the reply a backup's prepare engine sends after logging a Prepare. This block tracks the highest op acknowledged by each replica and advances the commit number once a majority quorum, counting the primary itself, has logged an op. Committed op numbers are emitted in order to the commit/execute path. New ops are admitted only while the outstanding window has space.

## Interface
Parameters:
- NUM_REPLICAS, 3: replica count; QUORUM = NUM_REPLICAS/2 + 1.
- OP_W, 64: op-number width.
- VIEW_W, 64: view-number width.
- WINDOW_LOG2, 4: maximum outstanding (issued, uncommitted) ops = 2^WINDOW_LOG2.
- IDX_W, $clog2(NUM_REPLICAS): replica-index width.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cur_view  in  VIEW_W  current view number
- my_replica_idx  in  IDX_W  this replica's index (the primary)
- issue_val  in  1  primary has sent Prepare for op issue_num+1
- issue_rdy  out  1  window has space and FSM is in IDLE
- manage_prepok_msg_val  in  1  PrepareOK metadata valid
- prepok_manage_msg_rdy  out  1  message consumed
- msg_view  in  VIEW_W  view field of the PrepareOK
- msg_op_num  in  OP_W  op field of the PrepareOK
- msg_replica_idx  in  IDX_W  sender index
- view_change_val  in  1  flush and rebase (highest priority)
- view_change_op_num  in  OP_W  new base op number
- commit_val  out  1  op commit_op_num committed
- commit_op_num  out  OP_W  committed op (commit_num+1)
- commit_rdy  in  1  downstream accepts commit
- commit_num  out  OP_W  last committed op
- issue_num  out  OP_W  last issued op
- window_full  out  1  issue_num − commit_num == 2^WINDOW_LOG2

## Operation
- State: commit_num, issue_num, and max_ack[NUM_REPLICAS] (OP_W each). The primary's own entry is treated as issue_num during the quorum count; its stored value is never used.
- FSM states:
  - IDLE:
    - prepok_manage_msg_rdy = 1 and issue_rdy = ~window_full.
    - On an issue handshake, issue_num++. This may happen in the same cycle as a message accept.
    - On a message handshake, the message is dropped (consumed, no state change, remain in IDLE) if any of these holds: msg_view != cur_view, msg_replica_idx >= NUM_REPLICAS, msg_replica_idx == my_replica_idx, msg_op_num > issue_num, or msg_op_num <= max_ack[idx].
    - Otherwise, max_ack[idx] <= msg_op_num and the FSM goes to CHECK. PrepareOK is cumulative.
  - CHECK:
    - n = commit_num+1.
    - cnt = number of replicas whose effective ack is >= n.
    - If commit_num < issue_num and cnt >= QUORUM, go to EMIT; else go to IDLE.
  - EMIT:
    - commit_val = 1 and commit_op_num = commit_num+1.
    - On commit_rdy, commit_num++ and go to CHECK.
- view_change_val takes effect in any state:
  - commit_num, issue_num and every max_ack are set to view_change_op_num.
  - State goes to IDLE, and any pending EMIT is abandoned.
  - The message and issue handshakes are suppressed that cycle (rdy outputs = 0).
- Arithmetic is unsigned OP_W. Op numbers never wrap (64-bit). The window comparison uses the full-width difference.

## Timing
- Reset: state = IDLE; commit_num, issue_num and all max_ack = 0. commit_val = 0 and window_full = 0. issue_rdy = 1 and prepok_manage_msg_rdy = 1 from the first cycle after reset. Reset mid-EMIT drops the pending commit.
- Accept of a valid message in cycle N: CHECK in N+1; commit_val asserted in N+2 at the earliest.
- commit_val, once asserted, holds with a stable commit_op_num until commit_rdy (or view_change).
- Back-to-back commits occur every 2 cycles (EMIT → CHECK → EMIT).
- issue_rdy and prepok_manage_msg_rdy are 0 outside IDLE. An issue that fills the window deasserts issue_rdy in the next cycle.
- A dropped message takes exactly 1 cycle.

## Configuration
- PREPOK_STATS_EN defined: adds outputs stat_drop_cnt[31:0] and stat_commit_cnt[31:0].
  - stat_drop_cnt counts dropped messages; stat_commit_cnt counts commit handshakes.
  - Both saturate at 2^32−1, reset to 0, and are unaffected by view_change.
- PREPOK_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- N=3, my=0: issue ops 1..3. Then PrepareOK (cur_view, op 3, r1), commit_rdy=1 → commit_val for 1, 2, 3 on alternate cycles starting 2 cycles after accept; commit_num=3.
- After that, PrepareOK r1 op 2 (stale) and a second PrepareOK with msg_view=cur_view+1 → both consumed in 1 cycle each, no commit_val, stat_drop_cnt=2.
- WINDOW_LOG2=2: issue 4 ops → window_full=1 and issue_rdy=0. PrepareOK r2 op 1 → commit 1, then window_full=0 and issue_rdy=1.
- N=5, my=0, 2 ops issued:
  - r1 op 2 → no commit.
  - r2 op 1 → commit 1 only.
  - r3 op 2 → commit 2.
- commit_rdy held low 10 cycles during EMIT → commit_val and commit_op_num stable. view_change_val with op 7 mid-EMIT → commit_val drops next cycle and commit_num=issue_num=7.
- Assert rst during EMIT → all outputs return to reset values next cycle.
